// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: central stall/flush controller for the PC register and the
// IF/ID, ID/EX, EX/ME and ME/WB pipeline registers. Arbitrates memory-wait,
// branch redirect, load-use and fetch-wait events, and sequences a redirect
// that arrives while an instruction fetch is still outstanding
// (RUN -> DRAIN -> ISSUE -> RUN).
// Optional performance counters: define PIPE_STALL_CTRL_PERF_EN.
module pipe_stall_ctrl #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_busy,
    input  logic              me_busy,
    input  logic              ld_use_hazard,
    input  logic              ex_redirect,
    input  logic [ADDR_W-1:0] ex_redirect_pc,
    output logic [1:0]        stall_pc,
    output logic [1:0]        stall_if_id,
    output logic [1:0]        stall_id_ex,
    output logic [1:0]        stall_ex_me,
    output logic [1:0]        stall_me_wb,
    output logic              pc_redirect_valid,
    output logic [ADDR_W-1:0] pc_redirect_target,
    output logic              if_discard
`ifdef PIPE_STALL_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]  perf_mem_stall,
    output logic [CNT_W-1:0]  perf_ld_use,
    output logic [CNT_W-1:0]  perf_redirect
`endif
);

    // Stall code encodings shared with the pipeline registers.
    localparam logic [1:0] STALL_NEXT = 2'b00;
    localparam logic [1:0] STALL_KEEP = 2'b01;
    localparam logic [1:0] STALL_ZERO = 2'b10;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        ISSUE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   tgt_q, tgt_d;

    // State and latched redirect target registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
        end
    end

    // Next-state and stall/redirect output decode.
    always_comb begin
        state_d            = state_q;
        tgt_d              = tgt_q;
        stall_pc           = STALL_NEXT;
        stall_if_id        = STALL_NEXT;
        stall_id_ex        = STALL_NEXT;
        stall_ex_me        = STALL_NEXT;
        stall_me_wb        = STALL_NEXT;
        pc_redirect_valid  = 1'b0;
        pc_redirect_target = (state_q == RUN) ? ex_redirect_pc : tgt_q;
        if_discard         = 1'b0;

        if (rst) begin
            state_d            = RUN;
            tgt_d              = '0;
            stall_pc           = STALL_ZERO;
            stall_if_id        = STALL_ZERO;
            stall_id_ex        = STALL_ZERO;
            stall_ex_me        = STALL_ZERO;
            stall_me_wb        = STALL_ZERO;
            pc_redirect_target = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (me_busy) begin
                        // EX is frozen, so a pending redirect is re-presented later.
                        stall_pc    = STALL_KEEP;
                        stall_if_id = STALL_KEEP;
                        stall_id_ex = STALL_KEEP;
                        stall_ex_me = STALL_KEEP;
                        stall_me_wb = STALL_ZERO;
                    end else if (ex_redirect && !if_busy) begin
                        pc_redirect_valid = 1'b1;
                        stall_if_id       = STALL_ZERO;
                        stall_id_ex       = STALL_ZERO;
                    end else if (ex_redirect) begin
                        // Fetch still in flight: park the target until it returns.
                        tgt_d       = ex_redirect_pc;
                        state_d     = DRAIN;
                        stall_pc    = STALL_KEEP;
                        stall_if_id = STALL_ZERO;
                        stall_id_ex = STALL_ZERO;
                        if_discard  = 1'b1;
                    end else if (ld_use_hazard) begin
                        stall_pc    = STALL_KEEP;
                        stall_if_id = STALL_KEEP;
                        stall_id_ex = STALL_ZERO;
                    end else if (if_busy) begin
                        stall_pc    = STALL_KEEP;
                        stall_if_id = STALL_ZERO;
                    end
                end
                DRAIN: begin
                    if_discard  = 1'b1;
                    stall_pc    = STALL_KEEP;
                    stall_if_id = STALL_ZERO;
                    stall_id_ex = STALL_ZERO;
                    if (me_busy) begin
                        stall_ex_me = STALL_KEEP;
                        stall_me_wb = STALL_ZERO;
                    end
                    if (!if_busy) begin
                        state_d = ISSUE;
                    end
                end
                ISSUE: begin
                    stall_if_id = STALL_ZERO;
                    stall_id_ex = STALL_ZERO;
                    if (me_busy) begin
                        stall_pc    = STALL_KEEP;
                        stall_ex_me = STALL_KEEP;
                        stall_me_wb = STALL_ZERO;
                    end else begin
                        pc_redirect_valid = 1'b1;
                        state_d           = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

`ifdef PIPE_STALL_CTRL_PERF_EN
    logic [CNT_W-1:0] perf_mem_q, perf_ld_q, perf_rd_q;
    logic             mem_evt, ld_evt;

    // me_busy forces KEEP in every state; rule 4 only fires in RUN unshadowed.
    assign mem_evt = !rst && me_busy;
    assign ld_evt  = !rst && (state_q == RUN) && ld_use_hazard && !me_busy && !ex_redirect;

    // Performance counters, wrapping modulo 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_mem_q <= '0;
            perf_ld_q  <= '0;
            perf_rd_q  <= '0;
        end else begin
            if (mem_evt)           perf_mem_q <= perf_mem_q + 1'b1;
            if (ld_evt)            perf_ld_q  <= perf_ld_q + 1'b1;
            if (pc_redirect_valid) perf_rd_q  <= perf_rd_q + 1'b1;
        end
    end

    assign perf_mem_stall = perf_mem_q;
    assign perf_ld_use    = perf_ld_q;
    assign perf_redirect  = perf_rd_q;
`else
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed scoreboard bench for pipe_stall_ctrl: each step drives inputs,
// pushes the expected outputs, and pops/compares them mid-cycle.
module tb_pipe_stall_ctrl;

    localparam logic [1:0] N = 2'b00;
    localparam logic [1:0] K = 2'b01;
    localparam logic [1:0] Z = 2'b10;

    logic        clk = 1'b0;
    logic        rst, if_busy, me_busy, ld_use_hazard, ex_redirect;
    logic [63:0] ex_redirect_pc;
    logic [1:0]  stall_pc, stall_if_id, stall_id_ex, stall_ex_me, stall_me_wb;
    logic        pc_redirect_valid, if_discard;
    logic [63:0] pc_redirect_target;
`ifdef PIPE_STALL_CTRL_PERF_EN
    logic [31:0] perf_mem_stall, perf_ld_use, perf_redirect;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [9:0]  codes;
        logic        valid;
        logic        chk_tgt;
        logic [63:0] tgt;
        logic        discard;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.ADDR_W(64), .CNT_W(32)) dut (
        .clk                (clk),
        .rst                (rst),
        .if_busy            (if_busy),
        .me_busy            (me_busy),
        .ld_use_hazard      (ld_use_hazard),
        .ex_redirect        (ex_redirect),
        .ex_redirect_pc     (ex_redirect_pc),
        .stall_pc           (stall_pc),
        .stall_if_id        (stall_if_id),
        .stall_id_ex        (stall_id_ex),
        .stall_ex_me        (stall_ex_me),
        .stall_me_wb        (stall_me_wb),
        .pc_redirect_valid  (pc_redirect_valid),
        .pc_redirect_target (pc_redirect_target),
        .if_discard         (if_discard)
`ifdef PIPE_STALL_CTRL_PERF_EN
        ,
        .perf_mem_stall     (perf_mem_stall),
        .perf_ld_use        (perf_ld_use),
        .perf_redirect      (perf_redirect)
`endif
    );

    function automatic logic [9:0] c5(input logic [1:0] p, input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] c, input logic [1:0] d);
        return {p, a, b, c, d};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic ifb, input logic meb,
                        input logic ld, input logic exr, input logic [63:0] rpc,
                        input logic [9:0] codes, input logic v, input logic ct,
                        input logic [63:0] t, input logic d);
        exp_t e;
        rst = r; if_busy = ifb; me_busy = meb; ld_use_hazard = ld;
        ex_redirect = exr; ex_redirect_pc = rpc;
        sb.push_back('{codes: codes, valid: v, chk_tgt: ct, tgt: t, discard: d});
        @(negedge clk);
        e = sb.pop_front();
        chk({tag, ".codes"}, {54'd0, stall_pc, stall_if_id, stall_id_ex, stall_ex_me, stall_me_wb},
            {54'd0, e.codes});
        chk({tag, ".valid"}, {63'd0, pc_redirect_valid}, {63'd0, e.valid});
        chk({tag, ".discard"}, {63'd0, if_discard}, {63'd0, e.discard});
        if (e.chk_tgt) chk({tag, ".target"}, pc_redirect_target, e.tgt);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $error("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset: everything ZERO, target 0.
        step("rst0", 1, 0, 0, 0, 0, 64'h0,  c5(Z,Z,Z,Z,Z), 0, 1, 64'h0, 0);
        step("rst1", 1, 1, 1, 1, 1, 64'hF0, c5(Z,Z,Z,Z,Z), 0, 1, 64'h0, 0);
        step("idle", 0, 0, 0, 0, 0, 64'h0,  c5(N,N,N,N,N), 0, 0, 64'h0, 0);

        // Redirect with fetch idle: taken in the same cycle.
        step("redir",  0, 0, 0, 0, 1, 64'h8000_0100, c5(N,Z,Z,N,N), 1, 1, 64'h8000_0100, 0);
        step("redir+", 0, 0, 0, 0, 0, 64'h0,          c5(N,N,N,N,N), 0, 0, 64'h0, 0);

        // Redirect while fetch busy for 3 cycles -> DRAIN -> ISSUE.
        step("drn0", 0, 1, 0, 0, 1, 64'h8000_0200, c5(K,Z,Z,N,N), 0, 0, 64'h0, 1);
        step("drn1", 0, 1, 0, 0, 0, 64'hDEAD,      c5(K,Z,Z,N,N), 0, 0, 64'h0, 1);
        step("drn2", 0, 1, 0, 0, 0, 64'hDEAD,      c5(K,Z,Z,N,N), 0, 0, 64'h0, 1);
        step("drn3", 0, 0, 0, 0, 0, 64'hDEAD,      c5(K,Z,Z,N,N), 0, 0, 64'h0, 1);
        step("iss",  0, 0, 0, 0, 0, 64'hDEAD,      c5(N,Z,Z,N,N), 1, 1, 64'h8000_0200, 0);
        step("iss+", 0, 0, 0, 0, 0, 64'h0,         c5(N,N,N,N,N), 0, 0, 64'h0, 0);

        // me_busy dominates load-use and redirect for 4 cycles.
        for (int unsigned i = 0; i < 4; i++)
            step("memb", 0, 0, 1, 1, 1, 64'h8000_0300, c5(K,K,K,K,Z), 0, 0, 64'h0, 0);
        step("memrel", 0, 0, 0, 1, 1, 64'h8000_0300, c5(N,Z,Z,N,N), 1, 1, 64'h8000_0300, 0);

        // Load-use bubble.
        step("lduse", 0, 0, 0, 1, 0, 64'h0, c5(K,K,Z,N,N), 0, 0, 64'h0, 0);
        // Fetch wait.
        step("ifb",   0, 1, 0, 0, 0, 64'h0, c5(K,Z,N,N,N), 0, 0, 64'h0, 0);
`ifdef PIPE_STALL_CTRL_PERF_EN
        chk("perf_ld_use",    {32'd0, perf_ld_use},    64'd1);
        chk("perf_mem_stall", {32'd0, perf_mem_stall}, 64'd4);
        chk("perf_redirect",  {32'd0, perf_redirect},  64'd3);
`endif

        // Redirect whose ISSUE is held 2 cycles by me_busy; me_busy also in DRAIN.
        step("d2r",  0, 1, 0, 0, 1, 64'h8000_0400, c5(K,Z,Z,N,N), 0, 0, 64'h0, 1);
        step("d2m",  0, 1, 1, 1, 1, 64'h0BAD,      c5(K,Z,Z,K,Z), 0, 0, 64'h0, 1);
        step("d2e",  0, 0, 0, 0, 0, 64'h0,         c5(K,Z,Z,N,N), 0, 0, 64'h0, 1);
        step("i2m0", 0, 0, 1, 0, 0, 64'h0,         c5(K,Z,Z,K,Z), 0, 0, 64'h0, 0);
        step("i2m1", 0, 0, 1, 0, 0, 64'h0,         c5(K,Z,Z,K,Z), 0, 0, 64'h0, 0);
        step("i2go", 0, 0, 0, 0, 0, 64'h0,         c5(N,Z,Z,N,N), 1, 1, 64'h8000_0400, 0);
        step("i2+",  0, 0, 0, 0, 0, 64'h0,         c5(N,N,N,N,N), 0, 0, 64'h0, 0);

        // Reset mid-DRAIN: latched target discarded, no stale redirect.
        step("d3r",  0, 1, 0, 0, 1, 64'h8000_0500, c5(K,Z,Z,N,N), 0, 0, 64'h0, 1);
        step("d3x",  1, 1, 0, 0, 0, 64'h0,         c5(Z,Z,Z,Z,Z), 0, 1, 64'h0, 0);
        step("post0", 0, 0, 0, 0, 0, 64'h0,        c5(N,N,N,N,N), 0, 0, 64'h0, 0);
        step("post1", 0, 0, 0, 0, 0, 64'h0,        c5(N,N,N,N,N), 0, 0, 64'h0, 0);
        step("post2", 0, 1, 0, 0, 0, 64'h0,        c5(K,Z,N,N,N), 0, 0, 64'h0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
